// File: rtl/utmi_rx_pkg.sv
// Shared encodings and defaults for the UTMI receive-control slice.
package utmi_rx_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned ERR_W   = 3;

  // FSM state encoding, also exported on state_o
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_DATA     = 3'd2,
    ST_EOP      = 3'd3,
    ST_ERR_WAIT = 3'd4
  } rx_state_e;

  // Error codes reported on err_code
  localparam logic [ERR_W-1:0] ERR_NONE   = 3'd0;
  localparam logic [ERR_W-1:0] ERR_SYNC   = 3'd1;
  localparam logic [ERR_W-1:0] ERR_STUFF  = 3'd2;
  localparam logic [ERR_W-1:0] ERR_BYTE   = 3'd3;
  localparam logic [ERR_W-1:0] ERR_EOP    = 3'd4;
  localparam logic [ERR_W-1:0] ERR_BABBLE = 3'd5;

endpackage

// File: rtl/utmi_rx_run_cnt.sv
// Saturating run-length counter: clear has priority; clear together with inc loads 1.
module utmi_rx_run_cnt #(
  parameter int unsigned LIMIT = 15,
  parameter int unsigned W     = $clog2(LIMIT + 1)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count register, holds at LIMIT
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && (cnt != W'(LIMIT))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/utmi_rx_ctrl.sv
// UTMI RX control FSM: SYNC hunt, data shifting, EOP qualification, error recovery.
// Optional babble (packet length) check enabled by defining UTMI_RX_BABBLE_EN.
module utmi_rx_ctrl
  import utmi_rx_pkg::*;
#(
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter int unsigned SE0_MAX_BITS = 4,
  parameter int unsigned SYNC_TO_BITS = 16,
  parameter int unsigned IDLE_J_BITS  = 7,
  parameter int unsigned MAX_BYTES    = 1027,
  parameter int unsigned CNT_W        = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sample,
  input  logic             J,
  input  logic             K,
  input  logic             SE0,
  input  logic             S_det,
  input  logic             S_err,
  input  logic             stuff_err,
  input  logic             byte_err,
  input  logic             RX_valid,
  output logic             S_en,
  output logic             shift_en,
  output logic             RX_active,
  output logic             RX_error,
  output logic             eop_detection,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [2:0]       state_o
);

  localparam int unsigned SE0_W = $clog2(SE0_MAX_BITS + 1);
  localparam int unsigned J_W   = $clog2(IDLE_J_BITS + 1);
  localparam int unsigned TO_W  = $clog2(SYNC_TO_BITS + 1);

  // byte_cnt must be able to show one byte past the babble limit
  if (MAX_BYTES + 1 > (2 ** CNT_W) - 1) begin : g_cnt_w_check
    $error("CNT_W too narrow for MAX_BYTES");
  end

  rx_state_e        state, state_n;
  logic [ERR_W-1:0] err_n;
  logic             err_set, eop_set, clr_bytes;
  logic             se0_clr, se0_inc, j_clr, j_inc, to_clr, to_inc;
  logic [SE0_W-1:0] se0_cnt;
  logic [J_W-1:0]   j_cnt;
  logic [TO_W-1:0]  to_cnt;

  utmi_rx_run_cnt #(.LIMIT(SE0_MAX_BITS), .W(SE0_W)) u_se0_run (
    .CLK(CLK), .RST(RST), .clr(se0_clr), .inc(se0_inc), .cnt(se0_cnt)
  );

  utmi_rx_run_cnt #(.LIMIT(IDLE_J_BITS), .W(J_W)) u_j_run (
    .CLK(CLK), .RST(RST), .clr(j_clr), .inc(j_inc), .cnt(j_cnt)
  );

  utmi_rx_run_cnt #(.LIMIT(SYNC_TO_BITS), .W(TO_W)) u_sync_to (
    .CLK(CLK), .RST(RST), .clr(to_clr), .inc(to_inc), .cnt(to_cnt)
  );

  // Next state, error latch and counter controls
  always_comb begin
    state_n   = state;
    err_n     = err_code;
    err_set   = 1'b0;
    eop_set   = 1'b0;
    clr_bytes = 1'b0;
    se0_clr   = 1'b1;
    se0_inc   = 1'b0;
    j_clr     = 1'b1;
    j_inc     = 1'b0;
    to_clr    = 1'b1;
    to_inc    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sample && K) begin
          state_n   = ST_SYNC;
          err_n     = ERR_NONE;
          clr_bytes = 1'b1;
        end
      end
      ST_SYNC: begin
        to_clr = 1'b0;
        to_inc = sample;
        if (S_det) begin
          state_n = ST_DATA;
        end else if (S_err || (sample && (to_cnt >= TO_W'(SYNC_TO_BITS - 1)))) begin
          state_n = ST_ERR_WAIT;
          err_set = 1'b1;
          err_n   = ERR_SYNC;
        end else if (sample && SE0) begin
          state_n = ST_IDLE;
          err_set = 1'b1;
          err_n   = ERR_SYNC;
        end
      end
      ST_DATA: begin
        if (stuff_err) begin
          state_n = ST_ERR_WAIT;
          err_set = 1'b1;
          err_n   = ERR_STUFF;
        end else if (sample && SE0) begin
          state_n = ST_EOP;
          se0_inc = 1'b1;
        end else if (byte_err) begin
          state_n = ST_ERR_WAIT;
          err_set = 1'b1;
          err_n   = ERR_BYTE;
        end
`ifdef UTMI_RX_BABBLE_EN
        else if (RX_valid && (byte_cnt == CNT_W'(MAX_BYTES))) begin
          state_n = ST_ERR_WAIT;
          err_set = 1'b1;
          err_n   = ERR_BABBLE;
        end
`else
`endif
      end
      ST_EOP: begin
        se0_clr = 1'b0;
        se0_inc = sample && SE0;
        if (stuff_err) begin
          state_n = ST_ERR_WAIT;
          err_set = 1'b1;
          err_n   = ERR_STUFF;
        end else if (byte_err) begin
          state_n = ST_ERR_WAIT;
          err_set = 1'b1;
          err_n   = ERR_BYTE;
        end else if (sample) begin
          if (SE0 && (se0_cnt >= SE0_W'(SE0_MAX_BITS))) begin
            state_n = ST_ERR_WAIT;
            err_set = 1'b1;
            err_n   = ERR_EOP;
          end else if (J && (se0_cnt >= SE0_W'(EOP_SE0_BITS))) begin
            state_n = ST_IDLE;
            eop_set = 1'b1;
          end else if (J || K) begin
            state_n = ST_ERR_WAIT;
            err_set = 1'b1;
            err_n   = ERR_EOP;
          end
        end
      end
      ST_ERR_WAIT: begin
        j_clr = sample && (K || SE0);
        j_inc = sample && J;
        if (sample && J && (j_cnt >= J_W'(IDLE_J_BITS - 1))) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, pulses, level outputs and saturating byte counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= ST_IDLE;
      err_code      <= ERR_NONE;
      RX_error      <= 1'b0;
      eop_detection <= 1'b0;
      S_en          <= 1'b0;
      shift_en      <= 1'b0;
      RX_active     <= 1'b0;
      byte_cnt      <= '0;
    end else begin
      state         <= state_n;
      err_code      <= err_n;
      RX_error      <= err_set;
      eop_detection <= eop_set;
      S_en          <= (state == ST_SYNC);
      shift_en      <= (state == ST_DATA);
      RX_active     <= (state == ST_DATA) || (state == ST_EOP);
      if (clr_bytes) begin
        byte_cnt <= '0;
      end else if ((state == ST_DATA) && RX_valid && (byte_cnt != '1)) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_utmi_rx_ctrl.sv
// Scoreboard bench for utmi_rx_ctrl: pulses checked by a monitor against queued expectations,
// levels checked directly after each step. Honors UTMI_RX_BABBLE_EN like the RTL.
module tb_utmi_rx_ctrl;

  localparam int unsigned CNT_W = 11;

  logic CLK = 1'b0;
  logic RST;
  logic sample, J, K, SE0, S_det, S_err, stuff_err, byte_err, RX_valid;
  logic S_en, shift_en, RX_active, RX_error, eop_detection;
  logic [2:0] err_code;
  logic [CNT_W-1:0] byte_cnt;
  logic [2:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit is_eop;
    int code;
    int cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  utmi_rx_ctrl #(
    .EOP_SE0_BITS(2), .SE0_MAX_BITS(4), .SYNC_TO_BITS(16),
    .IDLE_J_BITS(7), .MAX_BYTES(4), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .sample(sample), .J(J), .K(K), .SE0(SE0),
    .S_det(S_det), .S_err(S_err), .stuff_err(stuff_err), .byte_err(byte_err),
    .RX_valid(RX_valid), .S_en(S_en), .shift_en(shift_en), .RX_active(RX_active),
    .RX_error(RX_error), .eop_detection(eop_detection), .err_code(err_code),
    .byte_cnt(byte_cnt), .state_o(state_o)
  );

  // Monitor: every pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    if (RX_error || eop_detection) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pulse_unexpected: err=%0d eop=%0d code=%0d cnt=%0d, required no pulse",
                 RX_error, eop_detection, err_code, byte_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (eop_detection != e.is_eop || RX_error != !e.is_eop ||
            int'(err_code) != e.code || int'(byte_cnt) != e.cnt) begin
          miscompares++;
          $display("FAIL pulse: got err=%0d eop=%0d code=%0d cnt=%0d, required err=%0d eop=%0d code=%0d cnt=%0d",
                   RX_error, eop_detection, err_code, byte_cnt,
                   !e.is_eop, e.is_eop, e.code, e.cnt);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic expect_pulse(input bit is_eop, input int code, input int cnt);
    exp_t e;
    e.is_eop = is_eop;
    e.code   = code;
    e.cnt    = cnt;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; strobes return low afterwards, line state is kept
  task automatic drive(input logic s, input logic lj, input logic lk, input logic lse0,
                       input logic sd, input logic serr, input logic stf, input logic be,
                       input logic rv);
    sample = s; J = lj; K = lk; SE0 = lse0;
    S_det = sd; S_err = serr; stuff_err = stf; byte_err = be; RX_valid = rv;
    @(posedge CLK);
    #1;
    sample = 0; S_det = 0; S_err = 0; stuff_err = 0; byte_err = 0; RX_valid = 0;
  endtask

  task automatic smp_j();   drive(1, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic smp_k();   drive(1, 0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic smp_se0(); drive(1, 0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic sdet();    drive(0, J, K, SE0, 1, 0, 0, 0, 0); endtask
  task automatic rxv();     drive(0, J, K, SE0, 0, 0, 0, 0, 1); endtask
  task automatic idle1();   drive(0, J, K, SE0, 0, 0, 0, 0, 0); endtask

  task automatic recover();
    repeat (7) smp_j();
    chk("recover_state", int'(state_o), 0);
  endtask

  task automatic start_pkt();
    smp_k();
    sdet();
  endtask

  initial begin
    RST = 0; sample = 0; J = 1; K = 0; SE0 = 0;
    S_det = 0; S_err = 0; stuff_err = 0; byte_err = 0; RX_valid = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_state", int'(state_o), 0);
    chk("rst_active", int'(RX_active), 0);
    chk("rst_code", int'(err_code), 0);
    chk("rst_cnt", int'(byte_cnt), 0);
    @(negedge CLK);
    RST = 1;

    // Good packet
    smp_k();
    chk("t1_sync_state", int'(state_o), 1);
    sdet();
    chk("t1_s_en", int'(S_en), 1);
    chk("t1_data_state", int'(state_o), 2);
    repeat (3) rxv();
    chk("t1_shift_en", int'(shift_en), 1);
    chk("t1_bytes", int'(byte_cnt), 3);
    smp_se0();
    chk("t1_eop_state", int'(state_o), 3);
    smp_se0();
    expect_pulse(1, 0, 3);
    smp_j();
    chk("t1_idle", int'(state_o), 0);
    idle1();
    chk("t1_active_low", int'(RX_active), 0);

    // Stuff error after one byte, then J run recovery
    start_pkt();
    rxv();
    expect_pulse(0, 2, 1);
    drive(0, J, K, SE0, 0, 0, 1, 0, 0);
    chk("t2_state", int'(state_o), 4);
    chk("t2_code", int'(err_code), 2);
    chk("t2_active_lag", int'(RX_active), 1);
    idle1();
    chk("t2_active_low", int'(RX_active), 0);
    repeat (6) smp_j();
    chk("t2_still_wait", int'(state_o), 4);
    smp_j();
    chk("t2_idle", int'(state_o), 0);

    // SYNC timeout and S_err
    smp_k();
    chk("t3_cnt_clr", int'(byte_cnt), 0);
    repeat (15) smp_k();
    chk("t3_still_sync", int'(state_o), 1);
    expect_pulse(0, 1, 0);
    smp_k();
    chk("t3_to_state", int'(state_o), 4);
    chk("t3_to_code", int'(err_code), 1);
    recover();
    smp_k();
    chk("t3_code_clr", int'(err_code), 0);
    expect_pulse(0, 1, 0);
    drive(0, J, K, SE0, 0, 1, 0, 0, 0);
    chk("t3_serr_state", int'(state_o), 4);
    recover();

    // EOP faults: short SE0, long SE0, K after SE0
    start_pkt();
    smp_se0();
    expect_pulse(0, 4, 0);
    smp_j();
    chk("t4a_state", int'(state_o), 4);
    recover();
    start_pkt();
    repeat (4) smp_se0();
    chk("t4b_eop", int'(state_o), 3);
    expect_pulse(0, 4, 0);
    smp_se0();
    chk("t4b_state", int'(state_o), 4);
    recover();
    start_pkt();
    smp_se0();
    smp_se0();
    expect_pulse(0, 4, 0);
    smp_k();
    chk("t4c_code", int'(err_code), 4);
    recover();

    // Babble limit (MAX_BYTES=4)
    start_pkt();
    repeat (4) rxv();
`ifdef UTMI_RX_BABBLE_EN
    expect_pulse(0, 5, 5);
    rxv();
    chk("t5_state", int'(state_o), 4);
    chk("t5_code", int'(err_code), 5);
    recover();
`else
    rxv();
    chk("t5_state", int'(state_o), 2);
    chk("t5_cnt", int'(byte_cnt), 5);
    smp_se0();
    smp_se0();
    expect_pulse(1, 0, 5);
    smp_j();
`endif

    // Async reset mid-DATA, then RX_valid coincident with SE0
    start_pkt();
    rxv();
    idle1();
    chk("t6_active_pre", int'(RX_active), 1);
    @(negedge CLK);
    RST = 0;
    #1;
    chk("t6_rst_state", int'(state_o), 0);
    chk("t6_rst_active", int'(RX_active), 0);
    chk("t6_rst_shift", int'(shift_en), 0);
    @(posedge CLK);
    #1;
    chk("t6_rst_cnt", int'(byte_cnt), 0);
    @(negedge CLK);
    RST = 1;
    start_pkt();
    rxv();
    drive(1, 0, 0, 1, 0, 0, 0, 0, 1);
    chk("t6_sim_state", int'(state_o), 3);
    chk("t6_sim_cnt", int'(byte_cnt), 2);
    smp_se0();
    expect_pulse(1, 0, 2);
    smp_j();
    chk("t6_idle", int'(state_o), 0);
    repeat (2) idle1();

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pulse_missing: %0d expected pulses never seen, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
